// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// encodings, ALU operation codes and datapath select values.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    // ALU operation codes are shared with the ALU itself.
    localparam int ALU_CODE_W = 5;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR = 5'b00000;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL = 5'b00001;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL = 5'b00010;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA = 5'b00011;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 5'b00100;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 5'b00101;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 5'b01000;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 5'b01010;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 5'b01011;
    localparam logic [ALU_CODE_W-1:0] ALU_BEQ = 5'b01101;
    localparam logic [ALU_CODE_W-1:0] ALU_BNE = 5'b01110;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI = 5'b10010;

    localparam logic [1:0] SRC_B_REG    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    function automatic logic opcode_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller (master) and the datapath
// (slave): instruction fields and status in, strobes and selects out.
interface multicycle_control_if #(parameter int ALU_OP_W = 5);

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                alu_zero;
    logic                mem_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                ir_write;
    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                illegal;
    logic [2:0]          state;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
               illegal, state
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
               illegal, state
    );

endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU operation decode: picks the ALU op for the current state
// and flags opcodes or R-type functs the controller does not support.
module multicycle_control_alu_op_decode
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_W = 5
) (
    input  state_t              state,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal
);

    logic [ALU_CODE_W-1:0] code;

    // FETCH and DECODE always add (PC+4, branch target); EXEC follows the instruction.
    always_comb begin
        code    = ALU_XOR;
        illegal = 1'b0;
        case (state)
            ST_FETCH: code = ALU_ADD;
            ST_DECODE: begin
                code    = ALU_ADD;
                illegal = !opcode_supported(opcode);
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD:  code = ALU_ADD;
                            FN_SUB:  code = ALU_SUB;
                            FN_AND:  code = ALU_AND;
                            FN_OR:   code = ALU_OR;
                            FN_XOR:  code = ALU_XOR;
                            FN_SLT:  code = ALU_SLT;
                            FN_SLL:  code = ALU_SLL;
                            FN_SRL:  code = ALU_SRL;
                            FN_SRA:  code = ALU_SRA;
                            default: illegal = 1'b1;
                        endcase
                    end
                    OP_LW, OP_SW, OP_ADDI: code = ALU_ADD;
                    OP_LUI:  code = ALU_LUI;
                    OP_BEQ:  code = ALU_BEQ;
                    OP_BNE:  code = ALU_BNE;
                    default: illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_op = ALU_OP_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: five-state FETCH/DECODE/EXEC/MEM/WB FSM driving
// the datapath strobes; the state register is the only storage.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.master bus
);

    state_t              state_q;
    state_t              state_d;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_illegal;

    multicycle_control_alu_op_decode #(.ALU_OP_W(ALU_OP_W)) u_alu_op_decode (
        .state   (state_q),
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    assign bus.state = state_q;

    // Outputs are forced low while reset is held so a half-finished access never writes.
    always_comb begin
        state_d        = ST_FETCH;
        bus.alu_op     = '0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRC_B_REG;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_SRC_ALU;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.alu_op = dec_alu_op;
            case (state_q)
                ST_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRC_B_FOUR;
                    state_d       = ST_FETCH;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    bus.alu_src_b = SRC_B_IMM_SH;
                    if (dec_illegal) begin
                        bus.illegal = 1'b1;
                    end else if (bus.opcode == OP_J) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_SRC_JUMP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_illegal) begin
                        bus.illegal = 1'b1;
                    end else begin
                        case (bus.opcode)
                            OP_RTYPE: begin
                                bus.alu_src_a = 1'b1;
                                state_d       = ST_WB;
                            end
                            OP_LW, OP_SW: begin
                                bus.alu_src_a = 1'b1;
                                bus.alu_src_b = SRC_B_IMM;
                                state_d       = ST_MEM;
                            end
                            OP_ADDI: begin
                                bus.alu_src_a = 1'b1;
                                bus.alu_src_b = SRC_B_IMM;
                                state_d       = ST_WB;
                            end
                            OP_LUI: begin
                                bus.alu_src_b = SRC_B_IMM;
                                state_d       = ST_WB;
                            end
                            OP_BEQ, OP_BNE: begin
                                bus.alu_src_a = 1'b1;
                                // The ALU's branch ops clear the zero flag when the branch is taken.
                                if (!bus.alu_zero) begin
                                    bus.pc_write = 1'b1;
                                    bus.pc_src   = PC_SRC_TARGET;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MEM: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = (bus.opcode == OP_LW);
                    bus.mem_write = (bus.opcode == OP_SW);
                    state_d       = ST_MEM;
                    if (bus.mem_ready) begin
                        state_d = (bus.opcode == OP_LW) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (bus.opcode == OP_RTYPE);
                    bus.mem_to_reg = (bus.opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one vector per clock cycle, plus
// hand-written reset sequences for mid-instruction abort.
module tb_multicycle_control;

    localparam int ALU_OP_W = 5;

    // Strobe vector: {pc_write, pc_src[1:0], ir_write, mem_read, mem_write,
    //                 i_or_d, reg_write, reg_dst, mem_to_reg, illegal}
    localparam logic [10:0] S_NONE       = 11'b0_00_0_0_0_0_0_0_0_0;
    localparam logic [10:0] S_FETCH_WAIT = 11'b0_00_0_1_0_0_0_0_0_0;
    localparam logic [10:0] S_FETCH_GO   = 11'b1_00_1_1_0_0_0_0_0_0;
    localparam logic [10:0] S_BR_TAKEN   = 11'b1_01_0_0_0_0_0_0_0_0;
    localparam logic [10:0] S_JUMP       = 11'b1_10_0_0_0_0_0_0_0_0;
    localparam logic [10:0] S_MEM_LW     = 11'b0_00_0_1_0_1_0_0_0_0;
    localparam logic [10:0] S_MEM_SW     = 11'b0_00_0_0_1_1_0_0_0_0;
    localparam logic [10:0] S_WB_R       = 11'b0_00_0_0_0_0_1_1_0_0;
    localparam logic [10:0] S_WB_I       = 11'b0_00_0_0_0_0_1_0_0_0;
    localparam logic [10:0] S_WB_LW      = 11'b0_00_0_0_0_0_1_0_1_0;
    localparam logic [10:0] S_ILL        = 11'b0_00_0_0_0_0_0_0_0_1;

    // ALU field: {alu_op[4:0], alu_src_a, alu_src_b[1:0]}
    localparam logic [7:0] A_FETCH  = 8'b00100_0_01;
    localparam logic [7:0] A_DECODE = 8'b00100_0_11;
    localparam logic [7:0] A_MEMADR = 8'b00100_1_10;
    localparam logic [7:0] A_ADDI   = 8'b00100_0_10;
    localparam logic [7:0] A_LUI    = 8'b10010_0_10;
    localparam logic [7:0] A_BEQ    = 8'b01101_1_00;
    localparam logic [7:0] A_BNE    = 8'b01110_1_00;
    localparam logic [7:0] M_ALL    = 8'hFF;
    localparam logic [7:0] M_NO_A   = 8'b11111_0_11;
    localparam logic [7:0] M_NONE   = 8'h00;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [10:0] stb;
        logic [7:0]  alu;
        logic [7:0]  msk;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];

    multicycle_control_if #(.ALU_OP_W(ALU_OP_W)) bus ();

    multicycle_control #(.ALU_OP_W(ALU_OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy,
                                 input logic [2:0] st, input logic [10:0] stb,
                                 input logic [7:0] alu, input logic [7:0] msk);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.st = st; v.stb = stb; v.alu = alu; v.msk = msk;
        return v;
    endfunction

    task automatic push_fd(input logic [5:0] op, input logic [5:0] fn, input logic z);
        vecs.push_back(row(op, fn, z, 1'b1, 3'd0, S_FETCH_GO, A_FETCH, M_ALL));
        vecs.push_back(row(op, fn, z, 1'b1, 3'd1, S_NONE, A_DECODE, M_ALL));
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        bus.opcode    = v.op;
        bus.funct     = v.fn;
        bus.alu_zero  = v.z;
        bus.mem_ready = v.rdy;
        #1;
    endtask

    task automatic check_output(input vec_t v, input string name);
        logic [10:0] s;
        logic [7:0]  a;
        s = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
             bus.i_or_d, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};
        a = {bus.alu_op, bus.alu_src_a, bus.alu_src_b};
        checks++;
        if (bus.state !== v.st || s !== v.stb || (a & v.msk) !== (v.alu & v.msk)) begin
            failures++;
            $display("[TB] FAIL %s: got state=%0d strobes=%b alu=%b, want state=%0d strobes=%b alu=%b (mask %b)",
                     name, bus.state, s, a, v.st, v.stb, v.alu, v.msk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        apply_stimulus(v);
        check_output(v, name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] r_fn  [9];
        logic [4:0] r_aop [9];
        checks   = 0;
        failures = 0;

        r_fn[0] = 6'b100000; r_aop[0] = 5'b00100;
        r_fn[1] = 6'b100010; r_aop[1] = 5'b00101;
        r_fn[2] = 6'b100100; r_aop[2] = 5'b01010;
        r_fn[3] = 6'b100101; r_aop[3] = 5'b01000;
        r_fn[4] = 6'b100110; r_aop[4] = 5'b00000;
        r_fn[5] = 6'b101010; r_aop[5] = 5'b01011;
        r_fn[6] = 6'b000000; r_aop[6] = 5'b00001;
        r_fn[7] = 6'b000010; r_aop[7] = 5'b00010;
        r_fn[8] = 6'b000011; r_aop[8] = 5'b00011;

        // Instruction-fetch wait state, then each R-type funct: FETCH, DECODE, EXEC, WB.
        vecs.push_back(row(6'b000000, 6'b100000, 1'b0, 1'b0, 3'd0, S_FETCH_WAIT, 8'h00, M_NONE));
        for (int i = 0; i < 9; i++) begin
            push_fd(6'b000000, r_fn[i], 1'b0);
            vecs.push_back(row(6'b000000, r_fn[i], 1'b0, 1'b1, 3'd2, S_NONE, {r_aop[i], 3'b1_00}, M_ALL));
            vecs.push_back(row(6'b000000, r_fn[i], 1'b0, 1'b1, 3'd4, S_WB_R, 8'h00, M_NONE));
        end
        // addi, lui
        push_fd(6'b001000, 6'd0, 1'b0);
        vecs.push_back(row(6'b001000, 6'd0, 1'b0, 1'b1, 3'd2, S_NONE, A_ADDI, M_NO_A));
        vecs.push_back(row(6'b001000, 6'd0, 1'b0, 1'b1, 3'd4, S_WB_I, 8'h00, M_NONE));
        push_fd(6'b001111, 6'd0, 1'b0);
        vecs.push_back(row(6'b001111, 6'd0, 1'b0, 1'b1, 3'd2, S_NONE, A_LUI, M_NO_A));
        vecs.push_back(row(6'b001111, 6'd0, 1'b0, 1'b1, 3'd4, S_WB_I, 8'h00, M_NONE));
        // sw without wait states
        push_fd(6'b101011, 6'd0, 1'b0);
        vecs.push_back(row(6'b101011, 6'd0, 1'b0, 1'b1, 3'd2, S_NONE, A_MEMADR, M_ALL));
        vecs.push_back(row(6'b101011, 6'd0, 1'b0, 1'b1, 3'd3, S_MEM_SW, 8'h00, M_NONE));
        // lw with three memory wait cycles
        push_fd(6'b100011, 6'd0, 1'b0);
        vecs.push_back(row(6'b100011, 6'd0, 1'b0, 1'b1, 3'd2, S_NONE, A_MEMADR, M_ALL));
        for (int i = 0; i < 3; i++)
            vecs.push_back(row(6'b100011, 6'd0, 1'b0, 1'b0, 3'd3, S_MEM_LW, 8'h00, M_NONE));
        vecs.push_back(row(6'b100011, 6'd0, 1'b0, 1'b1, 3'd3, S_MEM_LW, 8'h00, M_NONE));
        vecs.push_back(row(6'b100011, 6'd0, 1'b0, 1'b1, 3'd4, S_WB_LW, 8'h00, M_NONE));
        // Branches: taken when alu_zero=0
        push_fd(6'b000100, 6'd0, 1'b0);
        vecs.push_back(row(6'b000100, 6'd0, 1'b0, 1'b1, 3'd2, S_BR_TAKEN, A_BEQ, M_ALL));
        push_fd(6'b000100, 6'd0, 1'b1);
        vecs.push_back(row(6'b000100, 6'd0, 1'b1, 1'b1, 3'd2, S_NONE, A_BEQ, M_ALL));
        push_fd(6'b000101, 6'd0, 1'b0);
        vecs.push_back(row(6'b000101, 6'd0, 1'b0, 1'b1, 3'd2, S_BR_TAKEN, A_BNE, M_ALL));
        push_fd(6'b000101, 6'd0, 1'b1);
        vecs.push_back(row(6'b000101, 6'd0, 1'b1, 1'b1, 3'd2, S_NONE, A_BNE, M_ALL));
        // Jump resolves in DECODE
        vecs.push_back(row(6'b000010, 6'd0, 1'b0, 1'b1, 3'd0, S_FETCH_GO, A_FETCH, M_ALL));
        vecs.push_back(row(6'b000010, 6'd0, 1'b0, 1'b1, 3'd1, S_JUMP, A_DECODE, M_ALL));
        // Unsupported opcode, then unsupported funct
        vecs.push_back(row(6'b111111, 6'd0, 1'b0, 1'b1, 3'd0, S_FETCH_GO, A_FETCH, M_ALL));
        vecs.push_back(row(6'b111111, 6'd0, 1'b0, 1'b1, 3'd1, S_ILL, 8'h00, M_NONE));
        push_fd(6'b000000, 6'b111111, 1'b0);
        vecs.push_back(row(6'b000000, 6'b111111, 1'b0, 1'b1, 3'd2, S_ILL, 8'h00, M_NONE));
        vecs.push_back(row(6'b000000, 6'b100000, 1'b0, 1'b0, 3'd0, S_FETCH_WAIT, 8'h00, M_NONE));

        // Reset with memory ready high: everything must stay quiet.
        rst           = 1'b1;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_output(row(6'd0, 6'd0, 1'b0, 1'b1, 3'd0, S_NONE, 8'h00, M_NONE), "reset_hold");
        bus.mem_ready = 1'b0;
        rst           = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // sw aborted by reset while waiting in MEM
        run_vec(row(6'b101011, 6'd0, 1'b0, 1'b1, 3'd0, S_FETCH_GO, A_FETCH, M_ALL), "sw_rst_fetch");
        run_vec(row(6'b101011, 6'd0, 1'b0, 1'b1, 3'd1, S_NONE, A_DECODE, M_ALL), "sw_rst_decode");
        run_vec(row(6'b101011, 6'd0, 1'b0, 1'b1, 3'd2, S_NONE, A_MEMADR, M_ALL), "sw_rst_exec");
        run_vec(row(6'b101011, 6'd0, 1'b0, 1'b0, 3'd3, S_MEM_SW, 8'h00, M_NONE), "sw_rst_mem");
        #2 rst = 1'b1;
        #1 check_output(row(6'b101011, 6'd0, 1'b0, 1'b0, 3'd0, S_NONE, 8'h00, M_NONE), "sw_rst_async");
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1 check_output(row(6'b101011, 6'd0, 1'b0, 1'b1, 3'd0, S_NONE, 8'h00, M_NONE), "sw_rst_held");
        bus.mem_ready = 1'b0;
        rst           = 1'b0;
        run_vec(row(6'b101011, 6'd0, 1'b0, 1'b0, 3'd0, S_FETCH_WAIT, 8'h00, M_NONE), "sw_rst_release");

        // add aborted by reset in WB; release straight into a jump fetch
        run_vec(row(6'b000000, 6'b100000, 1'b0, 1'b1, 3'd0, S_FETCH_GO, A_FETCH, M_ALL), "wb_rst_fetch");
        run_vec(row(6'b000000, 6'b100000, 1'b0, 1'b1, 3'd1, S_NONE, A_DECODE, M_ALL), "wb_rst_decode");
        run_vec(row(6'b000000, 6'b100000, 1'b0, 1'b1, 3'd2, S_NONE, 8'b00100_1_00, M_ALL), "wb_rst_exec");
        run_vec(row(6'b000000, 6'b100000, 1'b0, 1'b1, 3'd4, S_WB_R, 8'h00, M_NONE), "wb_rst_wb");
        #2 rst = 1'b1;
        #1 check_output(row(6'b000000, 6'b100000, 1'b0, 1'b1, 3'd0, S_NONE, 8'h00, M_NONE), "wb_rst_async");
        @(negedge clk);
        bus.opcode = 6'b000010;
        rst        = 1'b0;
        #1 check_output(row(6'b000010, 6'd0, 1'b0, 1'b1, 3'd0, S_FETCH_GO, A_FETCH, M_ALL), "wb_rst_release");
        run_vec(row(6'b000010, 6'd0, 1'b0, 1'b1, 3'd1, S_JUMP, A_DECODE, M_ALL), "wb_rst_jump");
        run_vec(row(6'b000010, 6'd0, 1'b0, 1'b0, 3'd0, S_FETCH_WAIT, 8'h00, M_NONE), "wb_rst_back");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: ALU_OP_W, 5, width of the ALU operation code driven to the ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 opcode  input  6  instruction bits [31:26], sampled from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 alu_zero  input  1  ALU zero flag; 1 when ALU result equals 0.
REQ-007 mem_ready  input  1  memory access done this cycle.
REQ-008 alu_op  output  ALU_OP_W  operation code to the ALU.
REQ-009 alu_src_a  output  1  0=PC, 1=register A.
REQ-010 alu_src_b  output  2  0=register B, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2.
REQ-011 pc_write, pc_src[1:0], ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg  outputs  datapath strobes and selects.
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode/funct.
REQ-013 state  output  3  current FSM state, for debug.

Function
REQ-014 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; every strobe not listed for a state SHALL be 0.
REQ-015 FETCH: mem_read=1 and i_or_d=0 while waiting; on mem_ready, ir_write=1, pc_write=1, pc_src=0, alu_op=ADD, src_a=0, src_b=1, then go to DECODE; without mem_ready, stay in FETCH.
REQ-016 DECODE: alu_op=ADD, src_a=0, src_b=3 (branch target precompute); j (000010) SHALL assert pc_write with pc_src=2 and return to FETCH; otherwise go to EXEC.
REQ-017 EXEC R-type (000000): funct 100000/100010/100100/100101/100110/101010/000000/000010/000011 SHALL map to ADD 00100/SUB 00101/AND 01010/OR 01000/XOR 00000/SLT 01011/SLL 00001/SRL 00010/SRA 00011; src_a=1, src_b=0; then go to WB.
REQ-018 EXEC lw (100011)/sw (101011): alu_op=ADD, src_a=1, src_b=2; then go to MEM. addi (001000): ADD with src_b=2, then WB. lui (001111): alu_op=LUI 10010 with src_b=2, then WB.
REQ-019 EXEC beq (000100)/bne (000101): alu_op=BEQ 01101/BNE 01110, src_a=1, src_b=0; branch taken when alu_zero=0, and then pc_write=1 with pc_src=1; return to FETCH in the same cycle.
REQ-020 MEM: i_or_d=1; lw asserts mem_read, sw asserts mem_write; stay until mem_ready; sw then goes to FETCH, lw goes to WB.
REQ-021 WB: reg_write=1 for one cycle; reg_dst=1 for R-type only; mem_to_reg=1 for lw only; then go to FETCH.
REQ-022 An unsupported opcode in DECODE, or an unsupported funct in EXEC, SHALL pulse illegal for one cycle, write nothing, and return to FETCH.
REQ-023 All outputs SHALL be combinational from state, opcode, funct, alu_zero and mem_ready; the only sequential element is the state register.
REQ-024 Each instruction class SHALL take a fixed number of cycles, given no memory wait states: j=2, branch=3, R/addi/lui=4, sw=4, lw=5.

Reset
REQ-025 rst=1 SHALL force state=FETCH immediately, independent of clk, and hold all strobes at 0 while asserted.
REQ-026 rst asserted mid-instruction SHALL abandon it with no register or memory write; after release, the first rising edge evaluates FETCH.

Structure
REQ-027 A shared package SHALL hold the state enum, the opcode and funct constants, and the ALU op constants, all common with the ALU.
REQ-028 One sub-module, alu_op_decode (combinational, opcode+funct+state -> alu_op, illegal), is natural; the FSM stays in the top module.

Verification
REQ-029 add (opcode 0, funct 100000), mem_ready=1 in FETCH -> states 0,1,2,4; alu_op=00100 in EXEC; reg_write=1, reg_dst=1 in WB.
REQ-030 beq with alu_zero=0 -> pc_write=1, pc_src=1 in EXEC; with alu_zero=1 -> no pc_write; next state is FETCH in both cases.
REQ-031 lw with mem_ready held low 3 cycles in MEM -> MEM held with mem_read=1, i_or_d=1; then WB with mem_to_reg=1.
REQ-032 opcode 111111 -> illegal pulses once in DECODE; no reg_write or mem_write; returns to FETCH.
REQ-033 rst asserted between edges during sw MEM -> state=0 and mem_write=0 immediately, with no memory write.
REQ-034 j (000010) -> pc_write=1, pc_src=2 in DECODE; 2 cycles total.
